// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame bit levels and the baud divider
// calculation used by both uart_tx and uart_rx_oversampled.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RESET_VALUE.
module uart_sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver with input synchronizer, false-start rejection, 3-sample majority voting and
// framing-error detection. Define UART_RX_PARITY_EN to add an even-parity bit and parity_error.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD_RATE     = 115_200,
  parameter int unsigned DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 received_bit,
  output logic [DATA_BITS-1:0] data_received,
  output logic                 data_valid,
  output logic                 framing_error,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 busy
);

  localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQUENCY, BAUD_RATE);
  localparam int unsigned HALF     = BAUD_DIV / 2;
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SMP0 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_SMP1 = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_EVAL = CNT_W'(HALF + 1);
  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);

  if (BAUD_DIV < 4) begin : g_baud_check
    $error("uart_rx_oversampled: BAUD_DIV must be at least 4");
  end

  logic rx_s;

  uart_sync_2ff #(
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (received_bit),
    .q     (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 maj;
  logic                 eval;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  // Third vote is the live sample at tgt+1; the first two were captured at tgt-1 and tgt.
  assign maj  = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign eval = (cnt_q == CNT_EVAL);

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    s0_d      = (cnt_q == CNT_SMP0) ? rx_s : s0_q;
    s1_d      = (cnt_q == CNT_SMP1) ? rx_s : s1_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rx_s == START_BIT) state_d = StStart;
      end
      StStart: begin
        // Counting on past HALF+1 keeps the wrap point on bit boundaries, so later bits
        // are sampled around their centres without reloading the counter.
        if (eval) begin
          if (maj != START_BIT) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_idx_d = '0;
          end
        end
      end
      StData: begin
        if (eval) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (eval) begin
          par_bad_d = maj ^ (^shift_q);
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (eval) begin
          if (maj == STOP_BIT) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
`else
            valid_d = 1'b1;
            data_d  = shift_q;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        if (rx_s == STOP_BIT) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_received = data_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = perr_q;
`endif
  assign busy          = (state_q != StIdle);

endmodule
